bi_piso: RTL
============

// Module: bi_piso
// PURPOSE
//  Parallel-in, serial-out bidirectional shift register: the transmit side of the
//  existing serial-in bidirectional shift register (bi). Accepts an MSB-bit word on
//  a valid/ready load handshake and emits it one bit per enabled clock on sout.
//  Bit order is chosen per word by dir. Feeding sout into bi's d, with the same dir
//  and en, rebuilds the word in bi's out after MSB enabled cycles.
// PARAMETERS
//  MSB   16   word width in bits; legal range >= 2
// PORTS
//  clk         in   1     single clock; all state updates on posedge clk
//  rst         in   1     synchronous, active-high reset
//  en          in   1     shift enable; sout advances only on cycles with en=1
//  dir         in   1     0 = MSB first (matches bi shift-left), 1 = LSB first (bi shift-right)
//  load_valid  in   1     din/dir hold a word to send
//  load_ready  out  1     block can accept a word this cycle
//  din         in   MSB   parallel word
//  sout        out  1     serial data bit
//  sout_valid  out  1     sout carries a word bit
//  last        out  1     current sout bit is the final bit of the word
//  busy        out  1     a word is in flight (state SHIFT)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=IDLE, shreg=0, cnt=0, dir_q=0. While rst=1,
//    sout=0, sout_valid=0, last=0, busy=0, load_ready=0. Reset mid-word drops the word.
//  - States: IDLE, SHIFT. Internal: shreg[MSB-1:0], dir_q, cnt[$clog2(MSB)-1:0].
//  - Accept = load_valid & load_ready. On accept: shreg<=din, dir_q<=dir, cnt<=0,
//    state<=SHIFT. dir is sampled only on accept; dir changes mid-word are ignored.
//  - IDLE: load_ready=1, sout=0, sout_valid=0, last=0, busy=0.
//  - SHIFT: sout_valid=1, busy=1, sout = dir_q ? shreg[0] : shreg[MSB-1],
//    last = (cnt==MSB-1).
//  - SHIFT with en=1 and not last: dir_q=0 -> shreg<=shreg<<1; dir_q=1 -> shreg<=shreg>>1.
//    Vacated bit is 0. cnt<=cnt+1.
//  - SHIFT with en=0: all state held, and sout/last stay stable. Stall length is unbounded.
//  - SHIFT with last=1 and en=1: the word completes.
//    - load_ready=1 in this cycle, so back-to-back words are zero-bubble.
//    - If accept occurs: reload as above and stay in SHIFT.
//    - Otherwise: state<=IDLE.
//  - load_ready = ~rst & (IDLE | (SHIFT & last & en)). It depends combinationally on en.
//  - Latency: a word accepted at edge N shows its first bit on sout after edge N.
//    The word takes exactly MSB en=1 cycles in SHIFT.
//  - cnt never wraps past MSB-1. Non-power-of-2 MSB must work, e.g. MSB=5.
//  - Simultaneous rst and load_valid: reset wins and nothing is accepted.
// STRUCTURE
//  - Shared header bi_defs.vh holds:
//    - localparams ST_IDLE=1'b0 and ST_SHIFT=1'b1;
//    - DIR_MSB_FIRST=1'b0 and DIR_LSB_FIRST=1'b1.
//    The bi receiver and its benches use the same header.
//  - One sub-module, bi_bit_cnt. Ports: clk, rst, clr, inc, cnt, is_last.
//    Parameterised by MSB; owns cnt and the last compare.
//  - Shift register, FSM and output decode stay in bi_piso.
// TESTING
//  1 Reset: hold rst=1 for 2 clk with load_valid=1 -> load_ready=0, sout_valid=0,
//    sout=0, no accept. After release, load_ready=1.
//  2 MSB-first: din=16'hA5C3, dir=0, en=1 -> sout = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1
//    over 16 cycles; last high only on the 16th; then IDLE.
//  3 LSB-first plus dir change: din=16'h0001, dir=1 -> sout=1 then fifteen 0s.
//    Toggling dir mid-word has no effect.
//  4 Stall: din=16'hFF00, dir=0, drop en for 5 cycles after bit 3 -> sout, last and
//    cnt frozen. Completion occurs after exactly 16 en=1 cycles.
//  5 Back-to-back: hold load_valid=1 with 16'h1234 then 16'hBEEF -> second word's
//    first bit follows the first word's last bit with no gap.
//  6 Loopback and reset mid-word:
//    - Loopback: sout->bi.d with shared en/dir, for MSB=16 and MSB=5 -> bi.out==din
//      after MSB en-cycles.
//    - Reset mid-word: rst at bit 7 -> IDLE next cycle, outputs 0.

Source files
------------

// File: rtl/bi_piso_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bi_piso_pkg
// Description : Shared FSM and bit-order encodings for the bi shift-register family.
// Revision    : 1.0 - initial release
// ============================================================================
package bi_piso_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_width(input int msb);
        return (msb > 2) ? $clog2(msb) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bi_piso_if.sv
`default_nettype none
// ============================================================================
// Interface   : bi_piso_if
// Description : Load handshake, shift control and serial output of bi_piso.
// Revision    : 1.0 - initial release
// ============================================================================
interface bi_piso_if #(
    parameter int MSB = 16
) ();

    logic           en;
    logic           dir;
    logic           load_valid;
    logic           load_ready;
    logic [MSB-1:0] din;
    logic           sout;
    logic           sout_valid;
    logic           last;
    logic           busy;

    modport master (
        output en, dir, load_valid, din,
        input  load_ready, sout, sout_valid, last, busy
    );

    modport slave (
        input  en, dir, load_valid, din,
        output load_ready, sout, sout_valid, last, busy
    );

endinterface
`default_nettype wire

// File: rtl/bi_bit_cnt.sv
`default_nettype none
// ============================================================================
// Module      : bi_bit_cnt
// Description : Bit-position counter for one word, with final-bit compare.
// Revision    : 1.0 - initial release
// ============================================================================
module bi_bit_cnt
    import bi_piso_pkg::*;
#(
    parameter int MSB = 16,
    localparam int CW = cnt_width(MSB)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          clr,
    input  wire logic          inc,
    output logic [CW-1:0]      cnt,
    output logic               is_last
);

    localparam logic [CW-1:0] C_LAST_IDX = CW'(MSB - 1);

    // Saturates at the final index so a non-power-of-2 width never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !is_last) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign is_last = (cnt == C_LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/bi_piso.sv
`default_nettype none
// ============================================================================
// Module      : bi_piso
// Description : Parallel-in, serial-out bidirectional shift register (bi transmitter).
// Revision    : 1.0 - initial release
// ============================================================================
module bi_piso
    import bi_piso_pkg::*;
#(
    parameter int MSB = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    bi_piso_if.slave  bus
);

    localparam int CW = cnt_width(MSB);

    logic [0:0]     r_state;
    logic [MSB-1:0] r_shreg;
    logic           r_dir;

    logic [CW-1:0]  w_cnt_unused;
    logic           w_last;
    logic           w_in_shift;
    logic           w_ready;
    logic           w_accept;
    logic           w_advance;
    logic           w_busy;

    assign w_in_shift = (r_state == ST_SHIFT);
    // Ready during the final enabled bit lets the next word follow with no bubble.
    assign w_ready    = ~rst & (~w_in_shift | (w_last & bus.en));
    assign w_accept   = bus.load_valid & w_ready;
    assign w_advance  = w_in_shift & bus.en & ~w_last;
    assign w_busy     = w_in_shift & ~rst;

    bi_bit_cnt #(
        .MSB (MSB)
    ) u_bit_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_accept),
        .inc     (w_advance),
        .cnt     (w_cnt_unused),
        .is_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_dir   <= DIR_MSB_FIRST;
        end else if (w_accept) begin
            r_state <= ST_SHIFT;
            r_shreg <= bus.din;
            r_dir   <= bus.dir;
        end else if (w_advance) begin
            if (r_dir == DIR_MSB_FIRST) begin
                r_shreg <= r_shreg << 1;
            end else begin
                r_shreg <= r_shreg >> 1;
            end
        end else if (w_in_shift && bus.en) begin
            r_state <= ST_IDLE;
        end
    end

    assign bus.load_ready = w_ready;
    assign bus.busy       = w_busy;
    assign bus.sout_valid = w_busy;
    assign bus.last       = w_busy & w_last;
    assign bus.sout       = w_busy & ((r_dir == DIR_LSB_FIRST) ? r_shreg[0] : r_shreg[MSB-1]);

endmodule
`default_nettype wire
